// File: rtl/prince_rand_scheduler.sv
// prince_rand_scheduler: double-buffered PRNG block fetch and rotated per-round mask delivery
module prince_rand_scheduler #(
  parameter int RW   = 188,
  parameter int STEP = 16,
  parameter int USES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    rounds,
  input  logic [RW-1:0] prng_data,
  input  logic          prng_valid,
  output logic          prng_ready,
  input  logic          round_req,
  output logic [RW-1:0] rand_out,
  output logic          rand_valid,
  output logic          busy,
  output logic          done
);
  localparam int IW = USES > 1 ? $clog2(USES) : 1;
  typedef enum logic [1:0] {IDLE, FILL, SERVE} state_t;
  state_t state, state_nx;
  logic [RW-1:0] active, shadow;
  logic [2*RW-1:0] dbl;
  logic av, sv, hs, consume, last_use, finish, keep_active;
  logic [IW-1:0] idx;
  logic [3:0] remain, uncovered, take;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next-state decode
  always_comb begin
    state_nx = state == IDLE ? ((start && rounds != 4'd0) ? FILL : IDLE) :
               state == FILL ? (hs ? SERVE : FILL) : (finish ? IDLE : SERVE);
  end
  // outputs decoded purely from registered state; rotate right via doubled word
  always_comb begin
    prng_ready = (state == FILL) | ((state == SERVE) & ~sv & (uncovered != 4'd0));
    rand_valid = (state == SERVE) & av;
    busy = state != IDLE;
    dbl = {active, active} >> (STEP * int'(idx));
    rand_out = rand_valid ? dbl[RW-1:0] : '0;
  end
  // handshake/consume events and the post-cycle validity of the active buffer
  always_comb begin
    hs = prng_ready & prng_valid;
    consume = round_req & rand_valid;
    last_use = consume & (idx == IW'(USES - 1));
    finish = consume & (remain == 4'd1);
    take = uncovered > 4'(USES) ? 4'(USES) : uncovered;
    keep_active = last_use ? sv : av;
  end
  // buffers and counters; a handshake landing on an exhausted active overrides the shadow move
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active <= '0;
      shadow <= '0;
      av <= 1'b0;
      sv <= 1'b0;
      idx <= '0;
      remain <= '0;
      uncovered <= '0;
      done <= 1'b0;
    end else begin
      done <= ((state == IDLE) & start & (rounds == 4'd0)) | finish;
      if (state == IDLE && start) begin
        remain <= rounds;
        uncovered <= rounds;
        idx <= '0;
      end else if (finish) begin
        active <= '0;
        shadow <= '0;
        av <= 1'b0;
        sv <= 1'b0;
        idx <= '0;
        remain <= '0;
        uncovered <= '0;
      end else begin
        if (consume) begin
          remain <= remain - 4'd1;
          idx <= last_use ? '0 : idx + 1'b1;
        end
        if (last_use) begin
          active <= shadow;
          av <= sv;
          shadow <= '0;
          sv <= 1'b0;
        end
        if (hs) begin
          uncovered <= uncovered - take;
          if (keep_active) begin
            shadow <= prng_data;
            sv <= 1'b1;
          end else begin
            active <= prng_data;
            av <= 1'b1;
          end
        end
      end
    end
endmodule
